// File: rtl/demux_1to3_buf.sv
`default_nettype none
// ============================================================================
// Module   : demux_1to3_buf
// Brief    : Registered 1-to-3 demultiplexer. Each input word goes to one of
//            three single-entry holding registers, and each register drains
//            through its own valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module demux_1to3_buf #(
    parameter int SIZE = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [SIZE-1:0] data_i,
    input  logic [1:0]      select_i,
    input  logic            valid_i,
    output logic            ready_o,
    output logic [SIZE-1:0] data0_o,
    output logic            valid0_o,
    input  logic            ready0_i,
    output logic [SIZE-1:0] data1_o,
    output logic            valid1_o,
    input  logic            ready1_i,
    output logic [SIZE-1:0] data2_o,
    output logic            valid2_o,
    input  logic            ready2_i,
    output logic            sel_err_o
);

    localparam int c_NUM_CH = 3;

    logic [c_NUM_CH-1:0]           w_onehot;
    logic [c_NUM_CH-1:0]           w_cons_rdy;
    logic                          w_accept;
    logic [c_NUM_CH-1:0]           r_valid_q;
    logic [c_NUM_CH-1:0]           w_valid_d;
    logic [c_NUM_CH-1:0][SIZE-1:0] r_data_q;
    logic [c_NUM_CH-1:0][SIZE-1:0] w_data_d;
    logic                          r_sel_err_q;
    logic                          w_sel_err_d;

    assign w_cons_rdy = {ready2_i, ready1_i, ready0_i};

    // Same priority as the datapath 3:1 mux: 2'b11 falls through to ch0
    always_comb begin
        w_onehot = 3'b001;
        case (select_i)
            2'b10:   w_onehot = 3'b100;
            2'b01:   w_onehot = 3'b010;
            default: w_onehot = 3'b001;
        endcase
    end

    // Target can take a word if it is empty or being drained on this edge
    assign ready_o  = rst_i && ~|(w_onehot & r_valid_q & ~w_cons_rdy);
    assign w_accept = valid_i && ready_o;

    always_comb begin
        w_valid_d   = r_valid_q;
        w_data_d    = r_data_q;
        w_sel_err_d = r_sel_err_q || (w_accept && (select_i == 2'b11));
        for (int k = 0; k < c_NUM_CH; k++) begin
            if (w_accept && w_onehot[k]) begin
                w_valid_d[k] = 1'b1;
                w_data_d[k]  = data_i;
            end else if (w_cons_rdy[k]) begin
                w_valid_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_valid_q   <= '0;
            r_data_q    <= '0;
            r_sel_err_q <= 1'b0;
        end else begin
            r_valid_q   <= w_valid_d;
            r_data_q    <= w_data_d;
            r_sel_err_q <= w_sel_err_d;
        end
    end

    assign data0_o   = r_data_q[0];
    assign data1_o   = r_data_q[1];
    assign data2_o   = r_data_q[2];
    assign valid0_o  = r_valid_q[0];
    assign valid1_o  = r_valid_q[1];
    assign valid2_o  = r_valid_q[2];
    assign sel_err_o = r_sel_err_q;

endmodule
`default_nettype wire

// File: tb/tb_demux_1to3_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_1to3_buf
// Brief    : Self-checking bench for demux_1to3_buf: directed scenarios plus a
//            randomized run against a behavioural channel model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_1to3_buf;

    localparam int SIZE = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [SIZE-1:0] d_in;
    logic [1:0]      sel;
    logic            vin;
    logic            rdy_out;
    logic [SIZE-1:0] d0, d1, d2;
    logic            v0, v1, v2;
    logic            r0, r1, r2;
    logic            err;

    int checks   = 0;
    int failures = 0;

    // Reference model: contents of each holding register plus the sticky flag
    logic [SIZE-1:0] m_data [3];
    bit              m_valid[3];
    bit              m_err;

    always #5 clk = ~clk;

    demux_1to3_buf #(.SIZE(SIZE)) dut (
        .clk_i    (clk),
        .rst_i    (rst_n),
        .data_i   (d_in),
        .select_i (sel),
        .valid_i  (vin),
        .ready_o  (rdy_out),
        .data0_o  (d0),
        .valid0_o (v0),
        .ready0_i (r0),
        .data1_o  (d1),
        .valid1_o (v1),
        .ready1_i (r1),
        .data2_o  (d2),
        .valid2_o (v2),
        .ready2_i (r2),
        .sel_err_o(err)
    );

    function automatic int tgt(input logic [1:0] s);
        if (s == 2'b10) return 2;
        if (s == 2'b01) return 1;
        return 0;
    endfunction

    function automatic logic cons_rdy(input int k);
        case (k)
            0:       return r0;
            1:       return r1;
            default: return r2;
        endcase
    endfunction

    function automatic logic [SIZE-1:0] dut_data(input int k);
        case (k)
            0:       return d0;
            1:       return d1;
            default: return d2;
        endcase
    endfunction

    function automatic logic dut_valid(input int k);
        case (k)
            0:       return v0;
            1:       return v1;
            default: return v2;
        endcase
    endfunction

    function automatic logic m_ready();
        int k;
        k = tgt(sel);
        return rst_n && (!m_valid[k] || cons_rdy(k));
    endfunction

    // One clock edge; the model advances from the inputs present at the edge
    task automatic tick();
        logic [SIZE-1:0] nd[3];
        bit              nv[3];
        bit              ne;
        int              k;
        k  = tgt(sel);
        ne = m_err;
        for (int c = 0; c < 3; c++) begin
            nd[c] = m_data[c];
            nv[c] = m_valid[c] && !cons_rdy(c);
        end
        if (vin && m_ready()) begin
            nv[k] = 1'b1;
            nd[k] = d_in;
            if (sel == 2'b11) ne = 1'b1;
        end
        if (!rst_n) begin
            for (int c = 0; c < 3; c++) begin
                nd[c] = '0;
                nv[c] = 1'b0;
            end
            ne = 1'b0;
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            m_data[c]  = nd[c];
            m_valid[c] = nv[c];
        end
        m_err = ne;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vin = 1'b1; d_in = 32'hFFFF_FFFF; sel = 2'b00;
        r0 = 1'b0; r1 = 1'b0; r2 = 1'b0;
        tick();
        tick();
        checks++; if ({d0, d1, d2} !== '0) begin failures++; $display("FAIL reset_data got=%h_%h_%h exp=0", d0, d1, d2); end
        checks++; if ({v0, v1, v2} !== 3'b000) begin failures++; $display("FAIL reset_valid got=%b%b%b exp=000", v0, v1, v2); end
        checks++; if (rdy_out !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", rdy_out); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        rst_n = 1'b1; vin = 1'b0;
        #1;
        checks++; if (rdy_out !== 1'b1) begin failures++; $display("FAIL idle_ready got=%b exp=1", rdy_out); end
    endtask

    task automatic test_steering();
        vin = 1'b1; d_in = 32'h11; sel = 2'b00;
        tick();
        checks++; if (d0 !== 32'h11 || v0 !== 1'b1) begin failures++; $display("FAIL steer_ch0 got=%h/%b exp=11/1", d0, v0); end
        checks++; if (v1 !== 1'b0 || v2 !== 1'b0) begin failures++; $display("FAIL steer_others0 got=%b%b exp=00", v1, v2); end
        d_in = 32'h22; sel = 2'b01;
        tick();
        checks++; if (d1 !== 32'h22 || v1 !== 1'b1) begin failures++; $display("FAIL steer_ch1 got=%h/%b exp=22/1", d1, v1); end
        checks++; if (d0 !== 32'h11 || v0 !== 1'b1 || v2 !== 1'b0) begin failures++; $display("FAIL steer_others1 got=%h/%b/%b", d0, v0, v2); end
        d_in = 32'h33; sel = 2'b10;
        tick();
        checks++; if (d2 !== 32'h33 || v2 !== 1'b1) begin failures++; $display("FAIL steer_ch2 got=%h/%b exp=33/1", d2, v2); end
        checks++; if (d1 !== 32'h22 || v1 !== 1'b1) begin failures++; $display("FAIL steer_keep1 got=%h/%b exp=22/1", d1, v1); end
        vin = 1'b0;
    endtask

    task automatic test_backpressure();
        r0 = 1'b1;
        tick();
        r0 = 1'b0;
        checks++; if (v0 !== 1'b0 || d0 !== 32'h11) begin failures++; $display("FAIL drain_ch0 got=%h/%b exp=11/0", d0, v0); end
        d_in = 32'hAB; sel = 2'b01; vin = 1'b1;
        #1;
        checks++; if (rdy_out !== 1'b0) begin failures++; $display("FAIL bp_ready got=%b exp=0", rdy_out); end
        tick();
        checks++; if (d1 !== 32'h22 || v1 !== 1'b1) begin failures++; $display("FAIL bp_hold got=%h/%b exp=22/1", d1, v1); end
        vin = 1'b0;
        tick();
        d_in = 32'hC0; sel = 2'b00; vin = 1'b1;
        #1;
        checks++; if (rdy_out !== 1'b1) begin failures++; $display("FAIL bp_other_ready got=%b exp=1", rdy_out); end
        tick();
        checks++; if (d0 !== 32'hC0 || v0 !== 1'b1) begin failures++; $display("FAIL bp_other_load got=%h/%b exp=c0/1", d0, v0); end
        d_in = 32'hAB; sel = 2'b01; r1 = 1'b1;
        #1;
        checks++; if (rdy_out !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", rdy_out); end
        tick();
        checks++; if (d1 !== 32'hAB || v1 !== 1'b1) begin failures++; $display("FAIL bp_refill got=%h/%b exp=ab/1", d1, v1); end
        vin = 1'b0; r1 = 1'b0;
    endtask

    task automatic test_back_to_back();
        r2 = 1'b1; sel = 2'b10; vin = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            d_in = i;
            #1;
            checks++; if (rdy_out !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, rdy_out); end
            tick();
            checks++; if (d2 !== i || v2 !== 1'b1) begin failures++; $display("FAIL b2b_data[%0d] got=%h/%b exp=%h/1", i, d2, v2, i); end
        end
        vin = 1'b0;
        tick();
        checks++; if (v2 !== 1'b0 || d2 !== 32'd8) begin failures++; $display("FAIL b2b_drain got=%h/%b exp=8/0", d2, v2); end
        r2 = 1'b0;
    endtask

    task automatic test_sel_err();
        logic [SIZE-1:0] w;
        int              k;
        r0 = 1'b1; d_in = 32'h5A; sel = 2'b11; vin = 1'b1;
        tick();
        checks++; if (d0 !== 32'h5A || v0 !== 1'b1) begin failures++; $display("FAIL selerr_ch0 got=%h/%b exp=5a/1", d0, v0); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL selerr_set got=%b exp=1", err); end
        r1 = 1'b1; r2 = 1'b1;
        for (int n = 0; n < 10; n++) begin
            w = $urandom; k = $urandom_range(0, 2);
            d_in = w; sel = 2'(k);
            tick();
            checks++; if (dut_data(k) !== w || dut_valid(k) !== 1'b1) begin failures++; $display("FAIL selerr_xfer[%0d] ch%0d got=%h exp=%h", n, k, dut_data(k), w); end
            checks++; if (err !== 1'b1) begin failures++; $display("FAIL selerr_sticky[%0d] got=%b exp=1", n, err); end
        end
        vin = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        r0 = 1'b0; r1 = 1'b0; r2 = 1'b0; vin = 1'b1;
        for (int k = 0; k < 3; k++) begin
            d_in = 32'h100 + k; sel = 2'(k);
            tick();
        end
        checks++; if ({v0, v1, v2} !== 3'b111) begin failures++; $display("FAIL rmid_full got=%b%b%b exp=111", v0, v1, v2); end
        d_in = 32'h77; sel = 2'b00; rst_n = 1'b0;
        tick();
        checks++; if ({v0, v1, v2} !== 3'b000) begin failures++; $display("FAIL rmid_valid got=%b%b%b exp=000", v0, v1, v2); end
        checks++; if ({d0, d1, d2} !== '0) begin failures++; $display("FAIL rmid_data got=%h_%h_%h exp=0", d0, d1, d2); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rmid_err got=%b exp=0", err); end
        rst_n = 1'b1; vin = 1'b0;
    endtask

    task automatic test_random();
        bit stalled = 1'b0;
        for (int n = 0; n < 400; n++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            r2 = 1'($urandom_range(0, 1));
            // A stalled source keeps its word; it may still retarget
            if (stalled) begin
                if ($urandom_range(0, 3) == 0) sel = 2'($urandom_range(0, 2));
            end else begin
                d_in = $urandom;
                sel  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                vin  = 1'($urandom_range(0, 1));
            end
            rst_n = ($urandom_range(0, 49) != 0);
            #1;
            checks++; if (rdy_out !== m_ready()) begin failures++; $display("FAIL rand_ready[%0d] got=%b exp=%b", n, rdy_out, m_ready()); end
            stalled = vin && !m_ready() && rst_n;
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (dut_data(k) !== m_data[k] || dut_valid(k) !== m_valid[k]) begin
                    failures++;
                    $display("FAIL rand_ch%0d[%0d] got=%h/%b exp=%h/%b", k, n, dut_data(k), dut_valid(k), m_data[k], m_valid[k]);
                end
            end
            checks++; if (err !== m_err) begin failures++; $display("FAIL rand_err[%0d] got=%b exp=%b", n, err, m_err); end
        end
        vin = 1'b0; rst_n = 1'b1;
    endtask

    initial begin
        for (int c = 0; c < 3; c++) begin
            m_data[c]  = '0;
            m_valid[c] = 1'b0;
        end
        m_err = 1'b0;
        test_reset();
        test_steering();
        test_backpressure();
        test_back_to_back();
        test_sel_err();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
